// File: rtl/countdown_timer.sv
// Countdown timer with IDLE/RUN/DONE control, registered outputs and expiry tick.
// Optional periodic reload on expiry when COUNTDOWN_RELOAD_EN is defined.
module countdown_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [1:0]       state_dbg,
  output logic [WIDTH-1:0] reload_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             tick_nxt;
  logic [WIDTH-1:0] start_val;

  // Value the countdown would begin from if start is taken this cycle.
  assign start_val = load ? load_val : count;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    tick_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
        end
        if (start) begin
          if (start_val != '0) begin
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_DONE;
            tick_nxt  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!pause) begin
          // Expiry also catches a zero count so the counter can never wrap.
          if (count <= WIDTH'(1)) begin
            tick_nxt = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
            if (reload != '0) begin
              count_nxt = reload;
            end else begin
              count_nxt = '0;
              state_nxt = S_DONE;
            end
`else
            count_nxt = '0;
            state_nxt = S_DONE;
`endif
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        count_nxt = '0;
        if (ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      count  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      busy   <= (state_nxt == S_RUN);
      done   <= (state_nxt == S_DONE);
      tick   <= tick_nxt;
    end
  end

  assign state_dbg  = state;
  assign reload_dbg = reload;

endmodule
